// File: rtl/iceboard_pkg.sv
// Shared constants, FSM states and CRC-16/CCITT-FALSE helper for the iCEboard motor UART link.
package iceboard_pkg;
  localparam logic [31:0] HEADER        = 32'hDEADBEEF;
  localparam int          PAYLOAD_BYTES = 13;
  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_PAYLOAD,
    ST_CRC_HI,
    ST_CRC_LO,
    ST_COMMIT
  } rx_state_t;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte combinational CRC-16/CCITT-FALSE step, shared by the RX and TX link sides.
module crc16_ccitt_byte
  import iceboard_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  assign crc_out = crc16_byte(crc_in, data);
endmodule

// File: rtl/iceboard_status_rx.sv
// Status frame parser for the iCEboard motor UART link: hunts headers, checks CRC16 and
// commits per-motor status plus link statistics.
//
// state      | meaning
// ST_HUNT    | scanning byte stream for the 4-byte header
// ST_PAYLOAD | collecting the 13 payload bytes, CRC running
// ST_CRC_HI  | waiting for received CRC high byte
// ST_CRC_LO  | waiting for received CRC low byte; verdict taken as it arrives
// ST_COMMIT  | one-cycle gap while frame_ok/frame_err is visible
module iceboard_status_rx
  import iceboard_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS    = 8,
  parameter int CLOCK_FREQ_HZ       = 50_000_000,
  parameter int BYTE_TIMEOUT_CYCLES = 2000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic signed [23:0] pwm                   [NUMBER_OF_MOTORS],
  output logic signed [23:0] encoder0_position     [NUMBER_OF_MOTORS],
  output logic signed [23:0] encoder1_position     [NUMBER_OF_MOTORS],
  output logic signed [23:0] displacement          [NUMBER_OF_MOTORS],
  output logic [31:0]        crc_checksum          [NUMBER_OF_MOTORS],
  output logic [31:0]        communication_quality [NUMBER_OF_MOTORS],
  output logic [31:0]        crc_error_count       [NUMBER_OF_MOTORS],
  output logic               frame_ok,
  output logic               frame_err
);
  localparam int            IDW      = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;
  localparam int            TW       = $clog2(BYTE_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(BYTE_TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   WIN_LAST = 32'(CLOCK_FREQ_HZ - 1);
  localparam logic [31:0]   MOTORS   = 32'(NUMBER_OF_MOTORS);

  rx_state_t      state, state_next;
  logic [23:0]    hdr_shift;
  logic [3:0]     byte_cnt;
  logic [15:0]    crc, crc_upd;
  logic [103:0]   payload;
  logic [7:0]     crc_hi;
  logic [TW-1:0]  idle_tmr;
  logic [31:0]    win_cnt;
  logic [31:0]    good_cnt [NUMBER_OF_MOTORS];
  logic           in_frame, timeout, header_hit, last_payload, win_wrap;
  logic [7:0]     motor_id;
  logic [IDW-1:0] motor_idx;
  logic           id_ok, crc_match;
  logic           commit_good, commit_bad_crc, err_next;

  crc16_ccitt_byte u_crc (
    .crc_in  (crc),
    .data    (rx_data),
    .crc_out (crc_upd)
  );

  assign in_frame     = (state == ST_PAYLOAD) || (state == ST_CRC_HI) || (state == ST_CRC_LO);
  assign timeout      = in_frame && !rx_valid && (idle_tmr == '0);
  assign header_hit   = rx_valid && ({hdr_shift, rx_data} == HEADER);
  assign last_payload = (byte_cnt == 4'(PAYLOAD_BYTES - 1));
  assign motor_id     = payload[103:96];
  assign motor_idx    = motor_id[IDW-1:0];
  assign id_ok        = 32'(motor_id) < MOTORS;
  assign crc_match    = ({crc_hi, rx_data} == crc);
  assign win_wrap     = (win_cnt == WIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_HUNT;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    commit_good    = 1'b0;
    commit_bad_crc = 1'b0;
    err_next       = 1'b0;
    case (state)
      ST_HUNT:    if (header_hit) state_next = ST_PAYLOAD;
      ST_PAYLOAD: if (rx_valid && last_payload) state_next = ST_CRC_HI;
      ST_CRC_HI:  if (rx_valid) state_next = ST_CRC_LO;
      ST_CRC_LO: begin
        if (rx_valid) begin
          state_next = ST_COMMIT;
          if (!id_ok) begin
            err_next = 1'b1;
          end else if (crc_match) begin
            commit_good = 1'b1;
          end else begin
            commit_bad_crc = 1'b1;
            err_next       = 1'b1;
          end
        end
      end
      ST_COMMIT:  state_next = ST_HUNT;
      default:    state_next = ST_HUNT;
    endcase
    if (timeout) begin
      state_next = ST_HUNT;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_shift <= '0;
      byte_cnt  <= '0;
      crc       <= '0;
      payload   <= '0;
      crc_hi    <= '0;
      idle_tmr  <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= commit_good;
      frame_err <= err_next;
      if (in_frame) begin
        if (rx_valid)              idle_tmr <= TMR_LOAD;
        else if (idle_tmr != '0)   idle_tmr <= idle_tmr - TW'(1);
      end
      case (state)
        ST_HUNT: begin
          if (header_hit) begin
            hdr_shift <= '0;
            byte_cnt  <= '0;
            crc       <= CRC_INIT;
            idle_tmr  <= TMR_LOAD;
          end else if (rx_valid) begin
            hdr_shift <= {hdr_shift[15:0], rx_data};
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid) begin
            payload  <= {payload[95:0], rx_data};
            crc      <= crc_upd;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        ST_CRC_HI: if (rx_valid) crc_hi <= rx_data;
        // A byte landing in the commit gap starts the next header search instead of being dropped.
        ST_COMMIT: hdr_shift <= rx_valid ? {16'h0, rx_data} : '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
        pwm[m]                   <= '0;
        encoder0_position[m]     <= '0;
        encoder1_position[m]     <= '0;
        displacement[m]          <= '0;
        crc_checksum[m]          <= '0;
        communication_quality[m] <= '0;
        crc_error_count[m]       <= '0;
        good_cnt[m]              <= '0;
      end
    end else begin
      win_cnt <= win_wrap ? '0 : win_cnt + 32'd1;
      if (win_wrap) begin
        for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
          communication_quality[m] <= good_cnt[m];
          good_cnt[m]              <= '0;
        end
      end
      if (commit_good) begin
        pwm[motor_idx]               <= payload[95:72];
        encoder0_position[motor_idx] <= payload[71:48];
        encoder1_position[motor_idx] <= payload[47:24];
        displacement[motor_idx]      <= payload[23:0];
        crc_checksum[motor_idx]      <= {16'h0, crc};
        // A commit in the wrap cycle belongs to the window that is just starting.
        if (win_wrap)                         good_cnt[motor_idx] <= 32'd1;
        else if (good_cnt[motor_idx] != '1)   good_cnt[motor_idx] <= good_cnt[motor_idx] + 32'd1;
      end
      if (commit_bad_crc && crc_error_count[motor_idx] != '1)
        crc_error_count[motor_idx] <= crc_error_count[motor_idx] + 32'd1;
    end
  end
endmodule

// File: tb/tb_iceboard_status_rx.sv
// Directed bench for iceboard_status_rx: a frame-level model is updated as frames are sent and
// every cycle all outputs are compared against it; literal checks pin the model.
module tb_iceboard_status_rx;
  localparam int N  = 8;
  localparam int CF = 1000;
  localparam int BT = 2000;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] rx_data;
  logic rx_valid;
  logic signed [23:0] pwm [N];
  logic signed [23:0] enc0 [N];
  logic signed [23:0] enc1 [N];
  logic signed [23:0] disp [N];
  logic [31:0] crc_checksum [N];
  logic [31:0] quality [N];
  logic [31:0] crc_errs [N];
  logic frame_ok, frame_err;

  always #5 clk = ~clk;

  iceboard_status_rx #(
    .NUMBER_OF_MOTORS(N), .CLOCK_FREQ_HZ(CF), .BYTE_TIMEOUT_CYCLES(BT)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .pwm(pwm), .encoder0_position(enc0), .encoder1_position(enc1), .displacement(disp),
    .crc_checksum(crc_checksum), .communication_quality(quality), .crc_error_count(crc_errs),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  logic [23:0] m_pwm [N], m_e0 [N], m_e1 [N], m_disp [N];
  logic [31:0] m_crc [N], m_qual [N], m_good [N], m_cerr [N];
  bit exp_ok, exp_err;
  int mcyc, checks, errors;

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [7:0] q [$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ q[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < N; m++) begin
      m_pwm[m] = 0; m_e0[m] = 0; m_e1[m] = 0; m_disp[m] = 0;
      m_crc[m] = 0; m_qual[m] = 0; m_good[m] = 0; m_cerr[m] = 0;
    end
    exp_ok = 0; exp_err = 0; mcyc = 0;
  endtask

  task automatic check_all();
    for (int m = 0; m < N; m++) begin
      check("pwm", m, {8'h0, pwm[m]}, {8'h0, m_pwm[m]});
      check("enc0", m, {8'h0, enc0[m]}, {8'h0, m_e0[m]});
      check("enc1", m, {8'h0, enc1[m]}, {8'h0, m_e1[m]});
      check("disp", m, {8'h0, disp[m]}, {8'h0, m_disp[m]});
      check("crc_checksum", m, crc_checksum[m], m_crc[m]);
      check("quality", m, quality[m], m_qual[m]);
      check("crc_error_count", m, crc_errs[m], m_cerr[m]);
    end
    check("frame_ok", -1, {31'h0, frame_ok}, {31'h0, exp_ok});
    check("frame_err", -1, {31'h0, frame_err}, {31'h0, exp_err});
  endtask

  // Compare, then advance one clock; the statistics window is tracked as edges since reset.
  task automatic tick();
    check_all();
    @(posedge clk);
    if (reset) mcyc = 0;
    else if (mcyc == CF - 1) begin
      for (int m = 0; m < N; m++) begin
        m_qual[m] = m_good[m];
        m_good[m] = 0;
      end
      mcyc = 0;
    end else mcyc++;
    #1;
    exp_ok = 0; exp_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [23:0] p, input logic [23:0] e0,
                            input logic [23:0] e1, input logic [23:0] d, input bit flip,
                            input bit hdr, input int gap, input bit sync_lo);
    logic [7:0] pl [$];
    logic [15:0] c;
    pl.push_back(id);
    for (int s = 16; s >= 0; s -= 8) pl.push_back(p[s +: 8]);
    for (int s = 16; s >= 0; s -= 8) pl.push_back(e0[s +: 8]);
    for (int s = 16; s >= 0; s -= 8) pl.push_back(e1[s +: 8]);
    for (int s = 16; s >= 0; s -= 8) pl.push_back(d[s +: 8]);
    c = ref_crc(pl);
    if (hdr) begin
      send_byte(8'hDE, gap); send_byte(8'hAD, gap); send_byte(8'hBE, gap); send_byte(8'hEF, gap);
    end
    foreach (pl[i]) send_byte(pl[i], gap);
    send_byte(c[15:8], gap);
    if (sync_lo) while (mcyc != CF - 1) tick();
    rx_data = c[7:0] ^ {7'h0, flip}; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
    if (id >= N) begin
      exp_err = 1;
    end else if (flip) begin
      if (m_cerr[id] != 32'hFFFF_FFFF) m_cerr[id]++;
      exp_err = 1;
    end else begin
      m_pwm[id] = p; m_e0[id] = e0; m_e1[id] = e1; m_disp[id] = d;
      m_crc[id] = {16'h0, c};
      if (m_good[id] != 32'hFFFF_FFFF) m_good[id]++;
      exp_ok = 1;
    end
  endtask

  initial begin
    logic [7:0] q [$];
    string s;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    checks = 0; errors = 0;
    model_clear();
    @(posedge clk); #1;
    repeat (3) tick();
    check("reset_pwm2", -1, {8'h0, pwm[2]}, 32'h0);
    check("reset_quality7", -1, quality[7], 32'h0);
    check("reset_frame_ok", -1, {31'h0, frame_ok}, 32'h0);
    reset = 1'b0;
    repeat (2) tick();

    s = "123456789";
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    check("ref_crc_123456789", -1, {16'h0, ref_crc(q)}, 32'h0000_29B1);

    // 1: good frame for motor 2
    send_frame(8'd2, 24'h000100, 24'hFFFFF6, 24'h001234, 24'h000020, 1'b0, 1'b1, 1, 1'b0);
    check("t1_frame_ok", -1, {31'h0, frame_ok}, 32'h1);
    check("t1_pwm2", -1, 32'(pwm[2]), 32'd256);
    check("t1_enc0_2", -1, 32'(enc0[2]), 32'hFFFF_FFF6);
    check("t1_pwm0", -1, 32'(pwm[0]), 32'd0);
    repeat (3) tick();

    // 2: same frame, corrupted CRC low byte
    send_frame(8'd2, 24'h000200, 24'hFFFFF6, 24'h001234, 24'h000020, 1'b1, 1'b1, 0, 1'b0);
    check("t2_frame_err", -1, {31'h0, frame_err}, 32'h1);
    check("t2_crc_errs2", -1, crc_errs[2], 32'd1);
    check("t2_pwm2_kept", -1, 32'(pwm[2]), 32'd256);
    repeat (3) tick();

    // 3: resync on a header preceded by junk
    send_byte(8'h00, 0); send_byte(8'hDE, 0); send_byte(8'hDE, 0);
    send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    send_frame(8'd0, 24'h7FFFFF, 24'h800000, 24'h000001, 24'hABCDEF, 1'b0, 1'b0, 0, 1'b0);
    check("t3_pwm0", -1, {8'h0, pwm[0]}, 32'h007F_FFFF);
    repeat (3) tick();

    // 4: byte timeout mid-payload, then a normal frame
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
    repeat (BT - 1) tick();
    check("t4_no_early_err", -1, {31'h0, frame_err}, 32'h0);
    tick();
    exp_err = 1;
    check("t4_timeout_err", -1, {31'h0, frame_err}, 32'h1);
    tick();
    send_frame(8'd1, 24'h000005, 24'h000006, 24'h000007, 24'h000008, 1'b0, 1'b1, 0, 1'b0);
    check("t4_pwm1", -1, 32'(pwm[1]), 32'd5);
    repeat (3) tick();

    // 5: motor id out of range with a valid CRC
    send_frame(8'd8, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 1'b0, 1'b1, 0, 1'b0);
    check("t5_frame_err", -1, {31'h0, frame_err}, 32'h1);
    repeat (3) tick();

    // 6: statistics window, back-to-back frames, frame committed in the wrap cycle
    while (mcyc != 10) tick();
    for (int k = 0; k < 5; k++)
      send_frame(8'd3, 24'(k), 24'h000010, 24'h000020, 24'h000030, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'd3, 24'h000099, 24'h000010, 24'h000020, 24'h000030, 1'b0, 1'b1, 0, 1'b1);
    check("t6_quality3_wrap", -1, quality[3], 32'd5);
    check("t6_wrap_frame_ok", -1, {31'h0, frame_ok}, 32'h1);
    while (mcyc != CF - 1) tick();
    tick();
    check("t6_quality3_next", -1, quality[3], 32'd1);

    // reset in the middle of a payload
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    reset = 1'b1;
    #1;
    model_clear();
    check("t6_reset_pwm3", -1, 32'(pwm[3]), 32'd0);
    check("t6_reset_crc_errs2", -1, crc_errs[2], 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) send_byte(8'h11 + 8'(i), 0);
    repeat (5) tick();
    check("t6_no_commit_after_reset", -1, 32'(pwm[3]), 32'd0);
    send_frame(8'd3, 24'h000042, 24'h000001, 24'h000002, 24'h000003, 1'b0, 1'b1, 0, 1'b0);
    check("t6_pwm3_after_reset", -1, 32'(pwm[3]), 32'h42);
    repeat (3) tick();
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
